edge_freq_meter: RTL

//  Measures the frequency of an external slow digital signal by counting its rising edges over a

---
 rtl/edge_freq_meter_pkg.sv | 15 +
 rtl/edge_freq_meter_if.sv | 12 +
 rtl/edge_freq_meter_bcd_sat_counter.sv | 42 ++++
 rtl/edge_freq_meter.sv | 70 +++++++
 4 files changed

// File: rtl/edge_freq_meter_pkg.sv
// edge_freq_meter_pkg: shared types, constants and helpers for the edge frequency meter
package freq_meter_pkg;
    typedef enum logic {IDLE, GATE} state_t;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam int MAX_DIGITS = 16;
    // Returns 9s in the lowest 'digits' BCD positions; callers slice to their own width.
    function automatic logic [4*MAX_DIGITS-1:0] bcd_all_nines(input int digits);
        logic [4*MAX_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (i < digits) r[4*i +: 4] = BCD_MAX_DIGIT;
        return r;
    endfunction
endpackage

// File: rtl/edge_freq_meter_if.sv
// edge_freq_meter_if: control and result bundle of the meter
//   en, sig_in            : master -> meter (enable, raw signal under test)
//   count_bcd, valid, overflow : meter -> master (packed BCD result, update pulse, saturation)
interface edge_freq_meter_if #(parameter int DIGITS = 4);
    logic en;
    logic sig_in;
    logic [4*DIGITS-1:0] count_bcd;
    logic valid;
    logic overflow;
    modport master(output en, sig_in, input count_bcd, valid, overflow);
    modport slave(input en, sig_in, output count_bcd, valid, overflow);
endinterface

// File: rtl/edge_freq_meter_bcd_sat_counter.sv
// bcd_sat_counter: chained saturating BCD counter
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count one event this cycle
//   bcd, sat : count and sticky saturation flag including this cycle's inc
module bcd_sat_counter
    import freq_meter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] bcd,
    output logic                sat
);
    localparam logic [4*MAX_DIGITS-1:0] NINES = bcd_all_nines(DIGITS);
    logic [4*DIGITS-1:0] q;
    logic q_sat, all9, carry;
    bcd_digit_t d;
    assign all9 = q == NINES[4*DIGITS-1:0];
    always_comb begin
        carry = inc & ~all9;
        bcd = q;
        d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = q[4*i +: 4];
            bcd[4*i +: 4] = carry ? (d == BCD_MAX_DIGIT ? 4'd0 : d + 4'd1) : d;
            carry = carry & (d == BCD_MAX_DIGIT);
        end
        sat = q_sat | (inc & all9);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            q <= '0;
            q_sat <= 1'b0;
        end else begin
            q <= clr ? '0 : bcd;
            q_sat <= clr ? 1'b0 : sat;
        end
endmodule

// File: rtl/edge_freq_meter.sv
// edge_freq_meter: counts rising edges of sig_in over a GATE_CYCLES window, reports packed BCD
//   clk, rst : clock, async active-high reset
//   bus      : en/sig_in in, count_bcd/valid/overflow out (edge_freq_meter_if.slave)
module edge_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int GATE_CYCLES = CLK_FREQ,
    parameter int SYNC_STAGES = 2,
    parameter int DIGITS      = 4
) (
    input logic clk,
    input logic rst,
    edge_freq_meter_if.slave bus
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic [GW-1:0] gate_cnt;
    logic [4*DIGITS-1:0] live, count_bcd;
    logic prev, edge_pulse, terminal, clr, sat, valid, overflow;
    assign edge_pulse = sync[SYNC_STAGES-1] & ~prev;
    assign terminal = state == GATE && gate_cnt == LAST;
    // Terminal clear restarts the next window at 0 while live/sat already include this cycle's edge.
    assign clr = state == IDLE || !bus.en || terminal;
    assign bus.count_bcd = count_bcd;
    assign bus.valid = valid;
    assign bus.overflow = overflow;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            prev <= sync[SYNC_STAGES-1];
        end
    bcd_sat_counter #(.DIGITS(DIGITS)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .inc(edge_pulse),
        .bcd(live),
        .sat(sat)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            gate_cnt <= '0;
            count_bcd <= '0;
            valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                gate_cnt <= '0;
                if (bus.en) state <= GATE;
            end else if (!bus.en) begin
                state <= IDLE;
                gate_cnt <= '0;
            end else if (terminal) begin
                gate_cnt <= '0;
                count_bcd <= live;
                overflow <= sat;
                valid <= 1'b1;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
            end
        end
endmodule
